// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and the buffered-entry layout for the instruction fetch stage
package ifetch_pkg;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous FIFO with clear, push/pop and occupancy count
module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) mem[wr_ptr] <= din;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: in-order instruction fetch with credit-limited requests, entry FIFO and redirect flush
// Define IFETCH_BYPASS_EN to present a response on inst_* in its arrival cycle when the FIFO is empty.
module inst_fetch
    import ifetch_pkg::*;
#(
    parameter int WORD_LEN = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [WORD_LEN-1:0] RESET_PC = WORD_LEN'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORD_LEN-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [WORD_LEN-1:0] imem_resp_data,
    input  logic                redirect_valid,
    input  logic [WORD_LEN-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [WORD_LEN-1:0] inst_data,
    output logic [WORD_LEN-1:0] inst_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WORD_LEN-1:0] STEP = WORD_LEN'(INST_BYTES);
    logic [WORD_LEN-1:0] fetch_pc, resp_pc, target;
    logic [CW-1:0] fifo_cnt, inflight_cnt, inflight_nxt, discard_cnt;
    logic [2*WORD_LEN-1:0] head;
    logic req_fire, resp_live, byp, push, pop, fifo_empty;
    assign target = redirect_pc & ~WORD_LEN'(3);
    assign fifo_empty = fifo_cnt == '0;
    assign imem_req_valid = !rst && !redirect_valid
        && ({1'b0, inflight_cnt} + {1'b0, fifo_cnt} < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr = rst ? RESET_PC : fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    // Stale responses and anything arriving alongside a redirect belong to the old stream.
    assign resp_live = imem_resp_valid && discard_cnt == '0 && !redirect_valid;
`ifdef IFETCH_BYPASS_EN
    assign byp = !rst && resp_live && fifo_empty;
`else
    assign byp = 1'b0;
`endif
    assign inst_valid = !rst && !redirect_valid && (!fifo_empty || byp);
    assign inst_pc = rst ? '0 : byp ? resp_pc : head[2*WORD_LEN-1:WORD_LEN];
    assign inst_data = rst ? '0 : byp ? imem_resp_data : head[WORD_LEN-1:0];
    assign push = resp_live && !(byp && inst_ready);
    assign pop = inst_valid && inst_ready && !fifo_empty;
    assign inflight_nxt = inflight_cnt + CW'(req_fire) - CW'(imem_resp_valid);
    fifo_sync #(.WIDTH(2*WORD_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clr(redirect_valid),
        .push(push),
        .pop(pop),
        .din({resp_pc, imem_resp_data}),
        .dout(head),
        .count(fifo_cnt)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            inflight_cnt <= '0;
            discard_cnt <= '0;
        end else begin
            inflight_cnt <= inflight_nxt;
            fetch_pc <= redirect_valid ? target : req_fire ? fetch_pc + STEP : fetch_pc;
            resp_pc <= redirect_valid ? target : resp_live ? resp_pc + STEP : resp_pc;
            discard_cnt <= redirect_valid ? inflight_nxt
                : (imem_resp_valid && discard_cnt != '0) ? discard_cnt - CW'(1) : discard_cnt;
        end
    end
    assert property (@(posedge clk) disable iff (rst) imem_resp_valid |-> inflight_cnt != '0);
endmodule
